// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC point rotator.
// Angle constants are scaled for a 10-bit angle fraction.
package cordic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROTATE,
    S_STORE,
    S_DONE
  } state_t;

  // Fraction bits and entry count of the angle constants below.
  localparam int TBL_FRAC = 10;
  localparam int TBL_LEN  = 12;

  // round((pi/2) * 2^10)
  localparam int PI_2 = 1608;

  // round(0.6072529 * 2^15), applied once per point to undo the CORDIC gain
  localparam logic signed [15:0] KINV       = 16'sd19898;
  localparam int                 KINV_SHIFT = 15;

  // round(atan(2^-i) * 2^10)
  function automatic int atan_val(input logic [3:0] i);
    case (i)
      4'd0:    atan_val = 804;
      4'd1:    atan_val = 475;
      4'd2:    atan_val = 251;
      4'd3:    atan_val = 127;
      4'd4:    atan_val = 64;
      4'd5:    atan_val = 32;
      4'd6:    atan_val = 16;
      4'd7:    atan_val = 8;
      4'd8:    atan_val = 4;
      4'd9:    atan_val = 2;
      4'd10:   atan_val = 1;
      default: atan_val = 0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// Combinational CORDIC helpers: quadrant pre-rotation of a source point
// and one micro-rotation with a run-time shift amount.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int DW = 12,
  parameter int AW = 13
) (
  input  logic signed [DW-1:0] src_x,
  input  logic signed [DW-1:0] src_y,
  input  logic signed [AW-1:0] theta,
  output logic signed [DW+1:0] pre_x,
  output logic signed [DW+1:0] pre_y,
  output logic signed [AW:0]   pre_z,
  input  logic signed [DW+1:0] x_in,
  input  logic signed [DW+1:0] y_in,
  input  logic signed [AW:0]   z_in,
  input  logic [3:0]           shift,
  output logic signed [DW+1:0] x_out,
  output logic signed [DW+1:0] y_out,
  output logic signed [AW:0]   z_out
);

  localparam logic signed [AW:0] HALF_PI = (AW+1)'(PI_2);

  logic signed [DW+1:0] sx, sy, xs, ys;
  logic signed [AW:0]   th, at;

  // Fold angles beyond +/-pi/2 into the CORDIC convergence range.
  always_comb begin
    sx    = (DW+2)'(src_x);
    sy    = (DW+2)'(src_y);
    th    = (AW+1)'(theta);
    pre_x = sx;
    pre_y = sy;
    pre_z = th;
    if (th > HALF_PI) begin
      pre_x = -sy;
      pre_y = sx;
      pre_z = th - HALF_PI;
    end else if (th < -HALF_PI) begin
      pre_x = sy;
      pre_y = -sx;
      pre_z = th + HALF_PI;
    end
  end

  // One micro-rotation; both coordinate updates use the incoming values.
  always_comb begin
    xs = x_in >>> shift;
    ys = y_in >>> shift;
    at = (AW+1)'(atan_val(shift));
    if (z_in[AW]) begin
      x_out = x_in + ys;
      y_out = y_in - xs;
      z_out = z_in + at;
    end else begin
      x_out = x_in - ys;
      y_out = y_in + xs;
      z_out = z_in - at;
    end
  end

endmodule

// File: rtl/cordic_point_rotator.sv
// Rotates a batch of buffered points by a common angle with an iterative
// CORDIC engine; results land in a second buffer for read-back.
module cordic_point_rotator
  import cordic_pkg::*;
#(
  parameter int N_POINTS = 18,
  parameter int DW       = 12,
  parameter int DFRAC    = 4,
  parameter int AW       = 13,
  parameter int AFRAC    = 10,
  parameter int ITER     = 12,
  localparam int AB      = $clog2(N_POINTS)
) (
  input  logic          CLOCK_50,
  input  logic          areset_n,
  input  logic          wr_en,
  input  logic [AB-1:0] wr_addr,
  input  logic [DW-1:0] wr_x,
  input  logic [DW-1:0] wr_y,
  input  logic          start,
  input  logic [AW-1:0] theta,
  input  logic [AB:0]   count,
  output logic          busy,
  output logic          done,
  input  logic [AB-1:0] rd_addr,
  output logic [DW-1:0] rd_x,
  output logic [DW-1:0] rd_y
);

  // The angle constants in cordic_pkg only hold for a 10-bit angle fraction.
  if (AFRAC != TBL_FRAC || ITER < 4 || ITER > AFRAC + 2 || ITER > TBL_LEN || DFRAC >= DW) begin : g_bad_params
    $error("cordic_point_rotator: unsupported parameter set");
  end

  localparam int PW = DW + 18;

  function automatic logic signed [DW+2:0] scale_kinv(input logic signed [DW+1:0] v);
    logic signed [PW-1:0] prod, sh;
    prod = PW'(v) * PW'(KINV);
    sh   = prod >>> KINV_SHIFT;
    return sh[DW+2:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+2:0] v);
    logic signed [DW+2:0] hi, lo;
    hi = (DW+3)'((1 << (DW-1)) - 1);
    lo = ~hi;
    if (v > hi) return hi[DW-1:0];
    if (v < lo) return lo[DW-1:0];
    return v[DW-1:0];
  endfunction

  logic signed [DW-1:0] src_x [N_POINTS];
  logic signed [DW-1:0] src_y [N_POINTS];
  logic signed [DW-1:0] res_x [N_POINTS];
  logic signed [DW-1:0] res_y [N_POINTS];

  state_t               state, state_nxt;
  logic [AB-1:0]        idx;
  logic [AB:0]          cnt_q, count_cl;
  logic [3:0]           it_q;
  logic signed [AW-1:0] theta_q;
  logic signed [DW+1:0] x_q, y_q, pre_x, pre_y, x_nxt, y_nxt;
  logic signed [AW:0]   z_q, pre_z, z_nxt;
  logic signed [DW-1:0] cur_x, cur_y;
  logic                 launch, last_iter, last_pt, wr_ok, rd_ok;

  assign count_cl  = (count > (AB+1)'(N_POINTS)) ? (AB+1)'(N_POINTS) : count;
  assign launch    = start && !busy && (state == S_IDLE || state == S_DONE);
  assign last_iter = (it_q == 4'(ITER-1));
  assign last_pt   = ({1'b0, idx} == cnt_q - 1'b1);
  assign wr_ok     = ({1'b0, wr_addr} < (AB+1)'(N_POINTS));
  assign rd_ok     = ({1'b0, rd_addr} < (AB+1)'(N_POINTS));
  assign cur_x     = src_x[idx];
  assign cur_y     = src_y[idx];

  // An empty batch stays busy through its single done cycle.
  assign busy = (state == S_FETCH) || (state == S_ROTATE) || (state == S_STORE) ||
                (state == S_DONE && cnt_q == '0);
  assign done = (state == S_DONE);

  cordic_stage #(.DW(DW), .AW(AW)) u_stage (
    .src_x (cur_x),
    .src_y (cur_y),
    .theta (theta_q),
    .pre_x (pre_x),
    .pre_y (pre_y),
    .pre_z (pre_z),
    .x_in  (x_q),
    .y_in  (y_q),
    .z_in  (z_q),
    .shift (it_q),
    .x_out (x_nxt),
    .y_out (y_nxt),
    .z_out (z_nxt)
  );

  // Batch sequencing: one fetch, ITER rotations and one store per point.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (launch) state_nxt = (count_cl == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:  state_nxt = S_ROTATE;
      S_ROTATE: if (last_iter) state_nxt = S_STORE;
      S_STORE:  state_nxt = last_pt ? S_DONE : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control registers: state, point index, iteration counter, batch size.
  always_ff @(posedge CLOCK_50 or negedge areset_n) begin
    if (!areset_n) begin
      state <= S_IDLE;
      idx   <= '0;
      it_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      it_q  <= (state == S_ROTATE && !last_iter) ? it_q + 4'd1 : 4'd0;
      if (launch) begin
        cnt_q <= count_cl;
        idx   <= '0;
      end else if (state == S_STORE && !last_pt) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Datapath: angle capture, pre-rotated load, then in-place micro-rotations.
  always_ff @(posedge CLOCK_50) begin
    if (launch) theta_q <= theta;
    if (state == S_FETCH) begin
      x_q <= pre_x;
      y_q <= pre_y;
      z_q <= pre_z;
    end else if (state == S_ROTATE) begin
      x_q <= x_nxt;
      y_q <= y_nxt;
      z_q <= z_nxt;
    end
  end

  // Source writes are only taken while no batch is running.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !busy && wr_ok) begin
      src_x[wr_addr] <= wr_x;
      src_y[wr_addr] <= wr_y;
    end
  end

  // Gain-compensated, saturated result write for the current point.
  always_ff @(posedge CLOCK_50) begin
    if (state == S_STORE) begin
      res_x[idx] <= sat_dw(scale_kinv(x_q));
      res_y[idx] <= sat_dw(scale_kinv(y_q));
    end
  end

  // Registered result read port.
  always_ff @(posedge CLOCK_50 or negedge areset_n) begin
    if (!areset_n) begin
      rd_x <= '0;
      rd_y <= '0;
    end else if (rd_ok) begin
      rd_x <= res_x[rd_addr];
      rd_y <= res_y[rd_addr];
    end
  end

endmodule

// File: tb/tb_cordic_point_rotator.sv
// Directed testbench for cordic_point_rotator with hand-computed results.
module tb_cordic_point_rotator;

  localparam int ITER = 12;
  localparam int NP   = 18;

  logic        CLOCK_50 = 1'b0;
  logic        areset_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [11:0] wr_x = '0, wr_y = '0;
  logic        start = 1'b0;
  logic [12:0] theta = '0;
  logic [5:0]  count = '0;
  logic        busy, done;
  logic [4:0]  rd_addr = '0;
  logic [11:0] rd_x, rd_y;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rx, ry, pulses;

  cordic_point_rotator dut (
    .CLOCK_50 (CLOCK_50),
    .areset_n (areset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .start    (start),
    .theta    (theta),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_x     (rd_x),
    .rd_y     (rd_y)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got < exp - tol || got > exp + tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, got, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    cyc++;
  endtask

  task automatic write_pt(input logic [4:0] a, input logic [11:0] x, input logic [11:0] y);
    wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y;
    step();
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [12:0] th, input logic [5:0] cn);
    start = 1'b1; theta = th; count = cn;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    while (done !== 1'b1 && cyc < exp_cyc + 50) step();
    check({tag, "_cycles"}, cyc, exp_cyc, 0);
    step();
  endtask

  task automatic read_pt(input logic [4:0] a, output int x, output int y);
    rd_addr = a;
    step();
    x = int'($signed(rd_x));
    y = int'($signed(rd_y));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #5 areset_n = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_rd_x", int'(rd_x), 0, 0);
    check("rst_rd_y", int'(rd_y), 0, 0);
    areset_n = 1'b1;
    step();

    // (16,0) by pi/4 -> (11.3125, 11.3125)
    write_pt(5'd0, 12'd256, 12'd0);
    launch(13'h324, 6'd1);
    wait_done("pi4", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("pi4_x", rx, 181, 2);
    check("pi4_y", ry, 181, 2);

    // Empty batch: done and busy for exactly one cycle
    launch(13'h324, 6'd0);
    check("cnt0_done", done, 1, 0);
    check("cnt0_busy", busy, 1, 0);
    step();
    check("cnt0_done_next", done, 0, 0);
    check("cnt0_busy_next", busy, 0, 0);

    // 18 points on the x axis rotated by pi/2, with ignored start/write
    for (int n = 1; n <= NP; n++) write_pt(5'(n - 1), 12'(16 * n), 12'd0);
    launch(13'h648, 6'd18);
    check("b18_busy", busy, 1, 0);
    start = 1'b1; theta = 13'd0; count = 6'd1;
    step();
    start = 1'b0;
    write_pt(5'd0, 12'hCE0, 12'hCE0);
    wait_done("b18", NP * (ITER + 2) + 1);
    for (int n = 1; n <= NP; n++) begin
      read_pt(5'(n - 1), rx, ry);
      check($sformatf("b18_x%0d", n), rx, 0, 2);
      check($sformatf("b18_y%0d", n), ry, 16 * n, 2);
    end

    // Oversized count is clamped to the buffer depth
    launch(13'h648, 6'd63);
    wait_done("clamp", NP * (ITER + 2) + 1);

    // Source 0 must still be (1,0) after the write during busy
    launch(13'h648, 6'd1);
    wait_done("src_keep", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("src_keep_x", rx, 0, 2);
    check("src_keep_y", ry, 16, 2);

    // (-22,0) by 3.0 rad -> (21.78, -3.10), positive quadrant fold
    write_pt(5'd0, 12'hEA0, 12'd0);
    launch(13'hC00, 6'd1);
    wait_done("q2", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("q2_x", rx, 348, 2);
    check("q2_y", ry, -50, 2);
    read_pt(5'd5, rx, ry);
    check("untouched_x5", rx, 0, 2);
    check("untouched_y5", ry, 96, 2);

    // (16,0) by -3.0 rad -> (-15.84, -2.26), negative quadrant fold
    write_pt(5'd0, 12'd256, 12'd0);
    launch(13'h1400, 6'd1);
    wait_done("q3", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("q3_x", rx, -253, 2);
    check("q3_y", ry, -36, 2);

    // Saturation at both ends of the output range
    write_pt(5'd0, 12'h7FF, 12'h7FF);
    launch(13'h324, 6'd1);
    wait_done("satp", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("satp_x", rx, 0, 2);
    check("satp_y", ry, 2047, 0);
    write_pt(5'd0, 12'h800, 12'h800);
    launch(13'h324, 6'd1);
    wait_done("satn", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("satn_x", rx, 0, 2);
    check("satn_y", ry, -2048, 0);

    // Reset in the middle of ROTATE aborts the batch silently
    write_pt(5'd0, 12'd256, 12'd0);
    write_pt(5'd1, 12'd256, 12'd0);
    launch(13'h324, 6'd2);
    for (int i = 0; i < 4; i++) step();
    check("abort_busy_before", busy, 1, 0);
    areset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0, 0);
    check("abort_done", done, 0, 0);
    step();
    check("abort_rd_x", int'(rd_x), 0, 0);
    areset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0, 0);
    write_pt(5'd0, 12'd256, 12'd0);
    launch(13'h324, 6'd1);
    wait_done("post_rst", ITER + 3);
    read_pt(5'd0, rx, ry);
    check("post_rst_x", rx, 181, 2);
    check("post_rst_y", ry, 181, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
